// File: rtl/ram_requester.sv
// ram_requester: load/store front end for a RAM with one-cycle read latency; loads return in order through a small response FIFO.
// Define RAM_REQUESTER_ALIGN_CHECK_EN to flag misaligned half/word accesses.
module ram_requester #(
    parameter int RSP_DEPTH = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        misalign_err,
    output logic [13:0] ram_address,
    output logic [3:0]  ram_byteena,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q
);
    localparam int AW = $clog2(RSP_DEPTH);
    typedef logic [AW:0] cnt_t;

    logic          accept, mis, push, pop;
    logic          pend_q, pend_d, psgn_q, psgn_d, perr_q, perr_d, merr_q, merr_d;
    logic [1:0]    poff_q, poff_d, psize_q, psize_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    cnt_t          cnt_q, cnt_d;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   ext;
    logic [32:0]   entry, head;
    logic [32:0]   fifo_q [RSP_DEPTH];

`ifdef RAM_REQUESTER_ALIGN_CHECK_EN
    assign mis = (req_size == 2'd1 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'd0);
`else
    assign mis = 1'b0;
`endif

    // Pending load counts against capacity so its push can never overflow the FIFO.
    assign req_ready    = (cnt_q + cnt_t'(pend_q)) < cnt_t'(RSP_DEPTH);
    assign accept       = req_valid && req_ready;
    assign ram_address  = req_addr[15:2];
    assign ram_byteena  = req_size == 2'd0 ? 4'b0001 << req_addr[1:0] :
                          req_size == 2'd1 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign ram_data     = req_size == 2'd0 ? {4{req_wdata[7:0]}} :
                          req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
    assign ram_wren     = accept && req_write && !mis;
    assign misalign_err = merr_q;

    assign lane_b = ram_q[{poff_q, 3'b000} +: 8];
    assign lane_h = poff_q[1] ? ram_q[31:16] : ram_q[15:0];
    assign ext    = psize_q == 2'd0 ? {{24{psgn_q & lane_b[7]}}, lane_b} :
                    psize_q == 2'd1 ? {{16{psgn_q & lane_h[15]}}, lane_h} : ram_q;
    assign entry  = perr_q ? {1'b1, 32'd0} : {1'b0, ext};

    assign push      = pend_q;
    assign rsp_valid = cnt_q != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign head      = fifo_q[rptr_q];
    assign rsp_rdata = rsp_valid ? head[31:0] : 32'd0;
    assign rsp_err   = rsp_valid && head[32];

    always_comb begin
        pend_d  = accept && !req_write;
        poff_d  = req_addr[1:0];
        psize_d = req_size;
        psgn_d  = req_signed;
        perr_d  = mis;
        merr_d  = merr_q | (accept && req_write && mis);
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        cnt_d   = cnt_q + cnt_t'(push) - cnt_t'(pop);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend_q  <= 1'b0;
            poff_q  <= 2'd0;
            psize_q <= 2'd0;
            psgn_q  <= 1'b0;
            perr_q  <= 1'b0;
            merr_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            poff_q  <= poff_d;
            psize_q <= psize_d;
            psgn_q  <= psgn_d;
            perr_q  <= perr_d;
            merr_q  <= merr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_q[wptr_q] <= entry;
    end
endmodule

// File: doc/ram_requester.md
RAM_REQUESTER -- requirements
Module: ram_requester

Interface
REQ-001 Parameter RSP_DEPTH, default 2, response FIFO entries; SHALL be a power of two >= 2.
REQ-002 clock  input  1  single clock; all state on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 = byte, 1 = half, 2 = word; 3 treated as word.
REQ-008 req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-009 req_addr  input  16  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid / rsp_ready  output / input  1 / 1  load response handshake.
REQ-012 rsp_rdata  output  32  extended load data; rsp_err  output  1  misaligned-load flag.
REQ-013 misalign_err  output  1  sticky misaligned-store flag.
REQ-014 ram_address  output  14  word address = req_addr[15:2].
REQ-015 ram_byteena  output  4; ram_data  output  32; ram_wren  output  1; ram_q  input  32, valid one cycle after address.

Function
REQ-016 Outputs SHALL be combinational from the request when accepted: ram_wren = accepted store, ram_address / ram_byteena / ram_data from request; ram_wren = 0 otherwise.
REQ-017 Byte enables SHALL be: byte -> 1 << addr[1:0]; half -> 4'b0011 << {addr[1],1'b0}; word -> 4'b1111.
REQ-018 Store data SHALL be replicated per lane: byte -> 4 copies of wdata[7:0]; half -> 2 copies of wdata[15:0]; word -> wdata.
REQ-019 Accepted load SHALL set a one-stage pending flag carrying addr[1:0], size, signed; next cycle ram_q lane is extracted (addr[1:0] selects byte, addr[1] selects half), extended, and pushed into the response FIFO.
REQ-020 Load-to-rsp_valid latency SHALL be 2 cycles with an empty FIFO (accept cycle, RAM cycle, then rsp_valid).
REQ-021 req_ready SHALL be 1 iff (FIFO count + pending) < RSP_DEPTH, independent of req_write and req_valid.
REQ-022 Stores SHALL produce no response; order of loads returned SHALL equal order accepted.
REQ-023 FIFO pops when rsp_valid && rsp_ready; push and pop in the same cycle SHALL leave the count unchanged.
REQ-024 rsp_rdata / rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-025 Full FIFO: req_ready = 0 until a pop; a pop in cycle N SHALL allow acceptance in cycle N+1 (req_ready registered from count).
REQ-026 FIFO pointers SHALL wrap modulo RSP_DEPTH.

Reset
REQ-027 On resetn low: req_ready = 1 after release, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, misalign_err = 0, pending cleared, FIFO empty, ram_wren = 0.
REQ-028 Reset mid-operation SHALL discard pending loads and FIFO contents; no response is ever delivered for them.

Configuration
REQ-029 Macro RAM_REQUESTER_ALIGN_CHECK_EN: when defined, half with addr[0]=1 or word with addr[1:0]!=0 is misaligned.
REQ-030 With macro: misaligned store SHALL have ram_wren = 0 and SHALL set misalign_err (sticky until reset); misaligned load SHALL not read the RAM data and SHALL return rsp_rdata = 0, rsp_err = 1 at the normal latency.
REQ-031 Without macro: no check; the low address bits beyond those in REQ-017 are ignored; rsp_err and misalign_err SHALL be constant 0. Ports are identical in both builds.

Verification
REQ-032 Store word 0xDEADBEEF @0x0100, then load word @0x0100 -> ram_byteena 4'b1111, rsp_rdata 0xDEADBEEF two cycles after accept.
REQ-033 Store byte 0x80 @0x0103, signed byte load @0x0103 -> byteena 4'b1000, rsp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-034 rsp_ready = 0 with 3 back-to-back loads (RSP_DEPTH = 2) -> third load stalls (req_ready = 0) until the first pop; responses are delivered in issue order.
REQ-035 With macro, half store @0x0201 -> ram_wren = 0, misalign_err = 1; word load @0x0202 -> rsp_err = 1, rsp_rdata 0.
REQ-036 resetn asserted with 1 pending load and 1 FIFO entry -> rsp_valid = 0 after release, no stale response; the next load returns the correct data.
